// File: rtl/bicubic_mac.sv
// Separable 4x4 bicubic MAC: row-serial pixel window in, one rounded and clamped pixel out.
// Optional window-sync checking on s_first with a sticky err is enabled by `define BICUBIC_MAC_SYNC_CHK_EN.
module bicubic_mac #(
    parameter int DATA_W = 8,
    parameter int WFRAC  = 7,
    parameter int ACC_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8:0]          bi_x0,
    input  logic [8:0]          bi_x1,
    input  logic [8:0]          bi_x2,
    input  logic [8:0]          bi_x3,
    input  logic [8:0]          bi_y0,
    input  logic [8:0]          bi_y1,
    input  logic [8:0]          bi_y2,
    input  logic [8:0]          bi_y3,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_first,
    input  logic [4*DATA_W-1:0] s_row,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_pixel,
    output logic                err
);
    localparam int WW  = 9;
    localparam int PRW = DATA_W + 1 + WW;
    localparam int HW  = PRW + 2;
    localparam int VW  = HW + WW;
    localparam int SH  = 2 * WFRAC;
    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1) <<< (SH - 1);
    localparam logic signed [ACC_W-1:0] PMAX  = ACC_W'((1 << DATA_W) - 1);

    logic [8:0] bi_x [4];
    logic [8:0] bi_y [4];

    assign bi_x[0] = bi_x0;
    assign bi_x[1] = bi_x1;
    assign bi_x[2] = bi_x2;
    assign bi_x[3] = bi_x3;
    assign bi_y[0] = bi_y0;
    assign bi_y[1] = bi_y1;
    assign bi_y[2] = bi_y2;
    assign bi_y[3] = bi_y3;

    logic en, beat, restart, row0, v_take;

    logic [1:0]                rc_q, rc_d;
    logic [8:0]                wx_q [4];
    logic [8:0]                wx_d [4];
    logic [8:0]                wy_q [4];
    logic [8:0]                wy_d [4];
    logic                      p_valid_q, p_valid_d;
    logic [1:0]                p_row_q, p_row_d;
    logic [4*DATA_W-1:0]       p_pix_q, p_pix_d;
    logic                      h_valid_q, h_valid_d;
    logic [1:0]                h_row_q, h_row_d;
    logic signed [HW-1:0]      h_sum_q, h_sum_d;
    logic signed [WW-1:0]      h_wy_q, h_wy_d;
    logic                      v_done_q, v_done_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      m_valid_q, m_valid_d;
    logic [DATA_W-1:0]         m_pixel_q, m_pixel_d;
    logic                      err_q, err_d;

    logic signed [PRW-1:0]     prod [4];
    logic signed [HW-1:0]      hsum_c;
    logic signed [VW-1:0]      vprod;
    logic signed [ACC_W-1:0]   rnd, rsh;
    logic [DATA_W-1:0]         pix_clamped;

    always_comb begin
        hsum_c = '0;
        for (int i = 0; i < 4; i++) begin
            prod[i] = PRW'(signed'({1'b0, p_pix_q[i*DATA_W +: DATA_W]})) * PRW'(signed'(wx_q[i]));
            hsum_c  = hsum_c + HW'(prod[i]);
        end
        vprod = VW'(h_sum_q) * VW'(h_wy_q);
        rnd   = acc_q + RND_C;
        rsh   = rnd >>> SH;
        if (rsh[ACC_W-1]) begin
            pix_clamped = '0;
        end else if (rsh > PMAX) begin
            pix_clamped = '1;
        end else begin
            pix_clamped = rsh[DATA_W-1:0];
        end
    end

`ifdef BICUBIC_MAC_SYNC_CHK_EN
    always_comb begin
        restart = s_valid && s_ready && s_first && (rc_q != 2'd0);
        err_d   = err_q || (s_valid && s_ready && (s_first != (rc_q == 2'd0)));
    end
`else
    logic first_unused;
    assign first_unused = s_first;
    always_comb begin
        restart = 1'b0;
        err_d   = 1'b0;
    end
`endif

    always_comb begin
        en   = !m_valid_q || m_ready;
        beat = s_valid && en;
        row0 = (rc_q == 2'd0) || restart;

        rc_d      = rc_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        p_valid_d = p_valid_q;
        p_row_d   = p_row_q;
        p_pix_d   = p_pix_q;
        h_valid_d = h_valid_q;
        h_row_d   = h_row_q;
        h_sum_d   = h_sum_q;
        h_wy_d    = h_wy_q;
        v_done_d  = v_done_q;
        acc_d     = acc_q;
        m_valid_d = m_valid_q;
        m_pixel_d = m_pixel_q;
        v_take    = 1'b0;

        if (beat) begin
            rc_d = restart ? 2'd1 : rc_q + 2'd1;
            if (row0) begin
                wx_d = bi_x;
                wy_d = bi_y;
            end
        end

        // A resync kills in-flight rows of the abandoned window; row 3 can only be the previous, complete window.
        if (en) begin
            p_valid_d = beat;
            p_row_d   = restart ? 2'd0 : rc_q;
            p_pix_d   = s_row;
            h_valid_d = p_valid_q && !(restart && p_row_q != 2'd3);
            h_row_d   = p_row_q;
            h_sum_d   = hsum_c;
            h_wy_d    = signed'(wy_q[p_row_q]);
            v_take    = h_valid_q && !(restart && h_row_q != 2'd3);
            v_done_d  = v_take && (h_row_q == 2'd3);
            if (v_take) begin
                acc_d = (h_row_q == 2'd0) ? ACC_W'(vprod) : acc_q + ACC_W'(vprod);
            end
            m_valid_d = v_done_q;
            if (v_done_q) begin
                m_pixel_d = pix_clamped;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                wx_q[i] <= '0;
                wy_q[i] <= '0;
            end
            p_valid_q <= 1'b0;
            p_row_q   <= '0;
            p_pix_q   <= '0;
            h_valid_q <= 1'b0;
            h_row_q   <= '0;
            h_sum_q   <= '0;
            h_wy_q    <= '0;
            v_done_q  <= 1'b0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_pixel_q <= '0;
            err_q     <= 1'b0;
        end else begin
            rc_q      <= rc_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            p_valid_q <= p_valid_d;
            p_row_q   <= p_row_d;
            p_pix_q   <= p_pix_d;
            h_valid_q <= h_valid_d;
            h_row_q   <= h_row_d;
            h_sum_q   <= h_sum_d;
            h_wy_q    <= h_wy_d;
            v_done_q  <= v_done_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_pixel_q <= m_pixel_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = en;
    assign m_valid = m_valid_q;
    assign m_pixel = m_pixel_q;
    assign err     = err_q;

endmodule
